// File: rtl/pfb_block_decimator_deadlock_reporter_if.sv
// Signal bundle between the deadlock reporter and the register bank / monitor side.
// The master drives the monitor inputs and clear; the slave (reporter) drives the report.
interface pfb_block_decimator_deadlock_reporter_if #(
  parameter int NUM_AXIS = 2,
  parameter int CNT_W    = 16,
  parameter int EVT_W    = 8,
  parameter int TS_W     = 32
);
  logic                block_in;
  logic [NUM_AXIS-1:0] axis_block_sigs;
  logic                clear;
  logic                deadlock;
  logic                recovered;
  logic [NUM_AXIS-1:0] deadlock_chan;
  logic [CNT_W-1:0]    blocked_cycles;
  logic [EVT_W-1:0]    event_count;
  logic [TS_W-1:0]     deadlock_ts;

  modport master (
    output block_in, axis_block_sigs, clear,
    input  deadlock, recovered, deadlock_chan, blocked_cycles, event_count, deadlock_ts
  );

  modport slave (
    input  block_in, axis_block_sigs, clear,
    output deadlock, recovered, deadlock_chan, blocked_cycles, event_count, deadlock_ts
  );
endinterface

// File: rtl/pfb_block_decimator_deadlock_reporter.sv
// Filters the decimator block flag and latches a sticky deadlock report after THRESHOLD cycles.
// Optional timestamp capture is enabled by defining PFB_DEADLOCK_REPORTER_TIMESTAMP_EN.
module pfb_block_decimator_deadlock_reporter #(
  parameter int NUM_AXIS  = 2,
  parameter int CNT_W     = 16,
  parameter int THRESHOLD = 1024,
  parameter int EVT_W     = 8,
  parameter int TS_W      = 32
) (
  input logic clock,
  input logic reset,
  pfb_block_decimator_deadlock_reporter_if.slave bus
);

  if ((THRESHOLD < 2) || (longint'(THRESHOLD) > ((longint'(1) << CNT_W) - 1))) begin : g_bad_threshold
    $error("THRESHOLD must lie in 2 .. 2**CNT_W-1");
  end

  typedef enum logic [1:0] {
    IDLE,
    SUSPECT,
    LATCHED
  } state_t;

  localparam logic [CNT_W-1:0] RUN_MAX = '1;
  localparam logic [CNT_W-1:0] TH      = CNT_W'(THRESHOLD);

  state_t              state, state_next;
  logic [CNT_W-1:0]    run, run_next, run_inc;
  logic                deadlock_q, deadlock_next;
  logic                recovered_q, recovered_next;
  logic [NUM_AXIS-1:0] chan_q, chan_next;
  logic [EVT_W-1:0]    evt_q, evt_next;
  logic                declare;

  assign run_inc = run + CNT_W'(1);

  // Declaration fires on the THRESHOLD-th consecutive high sample unless clear overrides it.
  always_comb begin
    state_next     = state;
    run_next       = run;
    deadlock_next  = deadlock_q;
    recovered_next = 1'b0;
    chan_next      = chan_q;
    evt_next       = evt_q;
    declare        = 1'b0;
    if (bus.clear) begin
      state_next    = IDLE;
      run_next      = '0;
      deadlock_next = 1'b0;
      chan_next     = '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.block_in) begin
            state_next = SUSPECT;
            run_next   = CNT_W'(1);
          end else begin
            run_next = '0;
          end
        end
        SUSPECT: begin
          if (bus.block_in) begin
            run_next = run_inc;
            if (run_inc == TH) begin
              declare       = 1'b1;
              state_next    = LATCHED;
              deadlock_next = 1'b1;
              chan_next     = bus.axis_block_sigs;
              if (evt_q != '1) evt_next = evt_q + EVT_W'(1);
            end
          end else begin
            state_next = IDLE;
            run_next   = '0;
          end
        end
        LATCHED: begin
          recovered_next = !bus.block_in;
          if (bus.block_in && (run != RUN_MAX)) run_next = run_inc;
        end
        default: begin
          state_next = IDLE;
          run_next   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      run         <= '0;
      deadlock_q  <= 1'b0;
      recovered_q <= 1'b0;
      chan_q      <= '0;
      evt_q       <= '0;
    end else begin
      state       <= state_next;
      run         <= run_next;
      deadlock_q  <= deadlock_next;
      recovered_q <= recovered_next;
      chan_q      <= chan_next;
      evt_q       <= evt_next;
    end
  end

`ifdef PFB_DEADLOCK_REPORTER_TIMESTAMP_EN
  logic [TS_W-1:0] ts_counter;
  logic [TS_W-1:0] ts_q;

  // Free-running time base; clear releases the captured stamp but never the counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      ts_counter <= '0;
      ts_q       <= '0;
    end else begin
      ts_counter <= ts_counter + TS_W'(1);
      if (bus.clear) ts_q <= '0;
      else if (declare) ts_q <= ts_counter;
    end
  end

  assign bus.deadlock_ts = ts_q;
`else
  assign bus.deadlock_ts = {TS_W{1'b0}};
`endif

  assign bus.deadlock       = deadlock_q;
  assign bus.recovered      = recovered_q;
  assign bus.deadlock_chan  = chan_q;
  assign bus.blocked_cycles = run;
  assign bus.event_count    = evt_q;

endmodule

// File: doc/pfb_block_decimator_deadlock_reporter.md
Name: pfb_block_decimator_deadlock_reporter

Overview:
- Downstream consumer of the decimator deadlock monitor's registered `block` flag and of the raw per-AXIS block vector.
- Filters transient blocking and declares a deadlock only after THRESHOLD consecutive blocked cycles.
- On declaration, latches a sticky flag, the guilty channel mask and the blocked-cycle count, and counts deadlock events.
- Feeds the correlator status/control register bank; software releases the sticky state with `clear`.

Parameters:
- NUM_AXIS, 2, width of the AXIS block vector.
- CNT_W, 16, width of the run-length / blocked-cycle counter.
- THRESHOLD, 1024, consecutive blocked cycles needed to declare deadlock; legal range 2 .. 2^CNT_W-1, otherwise elaboration error.
- EVT_W, 8, width of the event counter.
- TS_W, 32, width of the free-running timestamp.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- block_in  in  1  registered block flag from the deadlock monitor.
- axis_block_sigs  in  NUM_AXIS  raw per-AXIS block bits, same vector the monitor sees.
- clear  in  1  single-cycle pulse; releases the sticky report.
- deadlock  out  1  sticky deadlock flag.
- recovered  out  1  high while the report is latched but block_in=0.
- deadlock_chan  out  NUM_AXIS  axis_block_sigs captured at declaration.
- blocked_cycles  out  CNT_W  consecutive blocked cycles counted so far.
- event_count  out  EVT_W  number of declarations since reset.
- deadlock_ts  out  TS_W  timestamp of declaration (see Optional Feature).

Behaviour:
- All outputs are registered. Reset value of every output is 0; FSM resets to IDLE.
- Sampling: block_in is sampled at each rising edge. Run counter `run` drives blocked_cycles directly.
- FSM states: IDLE, SUSPECT, LATCHED.
- IDLE:
  - run=0.
  - block_in=1 -> SUSPECT, run<=1.
- SUSPECT:
  - block_in=1 -> run<=run+1.
  - If run+1==THRESHOLD -> LATCHED at the same edge, and at that edge:
    - deadlock<=1
    - deadlock_chan<=axis_block_sigs
    - event_count<=event_count+1, saturating at all-ones
    - deadlock_ts captured
  - block_in=0 -> IDLE, run<=0 (glitch filtered, no report).
- Declaration latency: deadlock is visible the cycle after the THRESHOLD-th consecutive high sample of block_in.
- LATCHED:
  - deadlock stays 1 regardless of block_in.
  - run increments while block_in=1 and saturates at 2^CNT_W-1 (no wrap).
  - run holds while block_in=0.
  - recovered = registered (state==LATCHED && block_in==0).
- clear, any state: next state IDLE.
  - Zeroed: run, deadlock, recovered, deadlock_chan, deadlock_ts.
  - event_count is not cleared; only reset clears it.
- clear and block_in=1 in the same cycle: clear wins, run=0. The following block_in samples restart from 1.
- Reaching THRESHOLD and clear in the same cycle: clear wins, no declaration, event_count unchanged.
- Reset mid-operation (any state): everything returns to reset values on the next edge; no partial report survives.
- axis_block_sigs is used only at the declaration edge; its value in other cycles is ignored.

Optional Feature:
- Macro: PFB_DEADLOCK_REPORTER_TIMESTAMP_EN.
- Defined:
  - A TS_W free-running counter runs from 0 after reset and wraps modulo 2^TS_W.
  - deadlock_ts captures the counter value at the declaration edge.
- Undefined:
  - No counter is instantiated; deadlock_ts is tied to 0.
  - All other behaviour is identical.

Test Plan (THRESHOLD=8 unless noted):
- block_in high for 7 cycles then low -> deadlock never asserts, blocked_cycles peaks at 7, then 0, event_count=0.
- block_in high for 8 cycles with axis_block_sigs=2'b10 at the 8th sample -> deadlock=1 on the next cycle, deadlock_chan=2'b10, blocked_cycles=8, event_count=1.
- Continue block_in high 20 more cycles, then drop low -> blocked_cycles=28, recovered=1, deadlock still 1. CNT_W=4 variant: blocked_cycles saturates at 15.
- clear pulse in LATCHED -> next cycle deadlock=0, deadlock_chan=0, blocked_cycles=0, event_count stays 1. A second 8-cycle block run -> event_count=2.
- clear asserted on the same cycle as the 8th high sample -> no declaration, run=0, event_count unchanged.
- Timestamp, macro defined: declaration at the edge where the counter reads 100 -> deadlock_ts=100. Macro undefined -> deadlock_ts=0. Reset asserted mid-SUSPECT -> all outputs 0 on the next cycle.
